// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding the IF/ID register.
// Keeps the PC and issues one request at a time over req/gnt/rvalid.
// Each fetched word goes out with its PC+PC_STEP. A one-entry skid buffer
// absorbs a response that arrives while downstream stalls, and redirects
// from later stages flush the stage.
// Optional macro FETCH_ALIGN_CHECK_EN adds the fetch_misalign output and
// turns a misaligned redirect into a NOP instead of a memory request.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IRout,
    output logic [31:0] NPC1out,
    output logic        if_valid,
    output logic [31:0] pc_out
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_misalign
`endif
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] npc1_q, npc1_d;
    logic        vld_q, vld_d;
    logic        mis_q, mis_d;
    logic [31:0] pc_next;

    assign pc_next = pc_q + PC_STEP;  // wraps modulo 2^32

    // Request is decoded from state. It is gated by rst so that no request
    // is issued during the reset cycle.
    assign imem_req  = (state_q == S_REQ) && !rst;
    assign imem_addr = pc_q;
    assign pc_out    = pc_q;
    assign IRout     = ir_q;
    assign NPC1out   = npc1_q;
    assign if_valid  = vld_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign fetch_misalign = mis_q;
`endif

    // Next-state, PC, skid and output-register computation
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        skid_d  = skid_q;
        ir_d    = ir_q;
        npc1_d  = npc1_q;
        vld_d   = stall ? vld_q : 1'b0;  // bubble unless something loads
        mis_d   = mis_q;
        if (redirect) begin
            pc_d   = redirect_pc;
            vld_d  = 1'b0;
            skid_d = '0;
            unique case (state_q)
                S_REQ:  state_d = imem_gnt ? S_DROP : S_REQ;
                S_WAIT: state_d = imem_rvalid ? S_REQ : S_DROP;
                S_HOLD: state_d = S_REQ;
                // A response that lands in the same cycle is the stale one
                // DROP was waiting for, so nothing is outstanding afterwards.
                S_DROP: state_d = imem_rvalid ? S_REQ : S_DROP;
                default: state_d = S_REQ;
            endcase
`ifdef FETCH_ALIGN_CHECK_EN
            // Misaligned target: present a NOP through the skid path and
            // never put the bad address on the memory port.
            if (redirect_pc[1:0] != 2'b00) begin
                state_d = S_HOLD;
                skid_d  = '0;
                mis_d   = 1'b1;
            end
`endif
        end else begin
            unique case (state_q)
                S_REQ: if (imem_gnt) state_d = S_WAIT;
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (!stall) begin
                            ir_d    = imem_rdata;
                            npc1_d  = pc_next;
                            vld_d   = 1'b1;
                            pc_d    = pc_next;
                            state_d = S_REQ;
                        end else begin
                            skid_d  = imem_rdata;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        ir_d    = skid_q;
                        npc1_d  = pc_next;
                        vld_d   = 1'b1;
                        pc_d    = pc_next;
                        state_d = S_REQ;
                    end
                end
                S_DROP: if (imem_rvalid) state_d = S_REQ;
                default: state_d = S_REQ;
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            skid_q  <= '0;
            ir_q    <= '0;
            npc1_q  <= '0;
            vld_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            skid_q  <= skid_d;
            ir_q    <= ir_d;
            npc1_q  <= npc1_d;
            vld_q   <= vld_d;
            mis_q   <= mis_d;
        end
    end

`ifndef FETCH_ALIGN_CHECK_EN
    logic unused_mis;
    assign unused_mis = mis_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: stimulus pushes expected request
// addresses and expected IF/ID outputs into queues. The memory model pops
// and compares addresses on each grant. The monitor pops and compares on
// each freshly loaded output.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic [31:0] IRout, NPC1out, pc_out;
    logic        if_valid;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_misalign, fetch_misalign2;
`endif

    // second instance: wrap-around reset PC with a trivial 1-cycle memory
    logic        req2, rv2 = 1'b0, vld2;
    logic [31:0] addr2, ir2, npc2, pc2;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] addr_q[$];
    logic [63:0] out_q[$];
    int          budget = 0;
    int          lat = 1;
    logic        stall_edge = 1'b0;

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .IRout(IRout), .NPC1out(NPC1out), .if_valid(if_valid), .pc_out(pc_out)
`ifdef FETCH_ALIGN_CHECK_EN
        , .fetch_misalign(fetch_misalign)
`endif
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst), .stall(1'b0), .redirect(1'b0),
        .redirect_pc(32'h0), .imem_req(req2), .imem_addr(addr2),
        .imem_gnt(1'b1), .imem_rvalid(rv2), .imem_rdata(32'h1234_5678),
        .IRout(ir2), .NPC1out(npc2), .if_valid(vld2), .pc_out(pc2)
`ifdef FETCH_ALIGN_CHECK_EN
        , .fetch_misalign(fetch_misalign2)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        stall_edge <= stall;
        rv2        <= req2 && !rst;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (k < 20) begin
            @(negedge clk);
            if (if_valid) break;
            k++;
        end
        if (k == 20) chk({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        case (a)
            32'h0000_3000: return 32'h2002_0005;
            32'h0000_3004: return 32'h2003_0007;
            default:       return a ^ 32'hA500_0000;
        endcase
    endfunction

    // Memory model: one outstanding request, fixed latency, grant budget.
    logic        pend = 1'b0;
    logic [31:0] paddr = '0;
    int          cnt = 0;
    always begin
        @(negedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (pend) begin
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word(paddr);
                pend        = 1'b0;
            end else cnt--;
        end
        if (imem_req && budget > 0) begin
            imem_gnt = 1'b1;
            budget--;
            if (addr_q.size() == 0) chk("req_addr_unexpected", {32'd0, imem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("req_addr", {32'd0, imem_addr}, {32'd0, addr_q.pop_front()});
            pend  = 1'b1;
            paddr = imem_addr;
            cnt   = lat - 1;
        end else imem_gnt = 1'b0;
    end

    // Monitor: a fresh output appears when if_valid is high after an unstalled edge.
    always begin
        @(negedge clk);
        if (!rst && if_valid && !stall_edge) begin
            if (out_q.size() == 0) chk("out_unexpected", {IRout, NPC1out}, 64'd0);
            else chk("out_ir_npc1", {IRout, NPC1out}, out_q.pop_front());
        end
    end

    // Wrap-around reset PC instance
    initial begin
        int k;
        @(negedge rst);
        #1;
        chk("w_first_addr", {31'd0, req2, addr2}, {31'd0, 1'b1, 32'hFFFF_FFFC});
        k = 0;
        while (k < 10 && !vld2) begin @(negedge clk); k++; end
        chk("w_npc1", {ir2, npc2}, {32'h1234_5678, 32'h0000_0000});
        chk("w_next_addr", {31'd0, req2, addr2}, {31'd0, 1'b1, 32'h0000_0000});
    end

    initial begin
        // reset state
        cyc(2);
        chk("rst_req", {63'd0, imem_req}, 64'd0);
        chk("rst_valid", {63'd0, if_valid}, 64'd0);
        chk("rst_ir_npc1", {IRout, NPC1out}, 64'd0);
        chk("rst_pc", {32'd0, pc_out}, 64'h0000_3000);

        // sequential fetch, 1-cycle memory
        rst = 1'b0;
        budget = 2;
        addr_q.push_back(32'h0000_3000); addr_q.push_back(32'h0000_3004);
        out_q.push_back({32'h2002_0005, 32'h0000_3004});
        out_q.push_back({32'h2003_0007, 32'h0000_3008});
        cyc(6);

        // response lands under a 3-cycle stall
        stall = 1'b1; budget = 1;
        addr_q.push_back(32'h0000_3008);
        out_q.push_back({32'hA500_3008, 32'h0000_300C});
        cyc(1);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("stall_hold_ir", {32'd0, IRout}, {32'd0, 32'h2003_0007});
        end
        stall = 1'b0;
        cyc(3);

        // redirect while waiting, no rvalid: stale response dropped
        lat = 3; budget = 1;
        addr_q.push_back(32'h0000_300C);
        cyc(1);
        redirect = 1'b1; redirect_pc = 32'h0000_3040;
        cyc(1);
        redirect = 1'b0; lat = 1; budget = 1;
        addr_q.push_back(32'h0000_3040);
        out_q.push_back({32'hA500_3040, 32'h0000_3044});
        wait_valid("redir_wait");

        // redirect in the same cycle as rvalid, with stall held
        stall = 1'b1; budget = 1;
        addr_q.push_back(32'h0000_3044);
        cyc(1);
        redirect = 1'b1; redirect_pc = 32'h0000_3080;
        cyc(1);
        chk("redir_rv_valid", {63'd0, if_valid}, 64'd0);
        chk("redir_rv_ir", {32'd0, IRout}, {32'd0, 32'hA500_3040});
        redirect = 1'b0; stall = 1'b0; budget = 1;
        addr_q.push_back(32'h0000_3080);
        out_q.push_back({32'hA500_3080, 32'h0000_3084});
        wait_valid("redir_rv");

        // PC wrap through redirect to the top of the address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cyc(1);
        redirect = 1'b0; budget = 2;
        addr_q.push_back(32'hFFFF_FFFC); addr_q.push_back(32'h0000_0000);
        out_q.push_back({32'h5AFF_FFFC, 32'h0000_0000});
        out_q.push_back({32'hA500_0000, 32'h0000_0004});
        cyc(8);

`ifdef FETCH_ALIGN_CHECK_EN
        // misaligned redirect becomes a NOP without a memory request
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_3042;
        cyc(1);
        redirect = 1'b0;
        chk("mis_req", {63'd0, imem_req}, 64'd0);
        chk("mis_flag", {63'd0, fetch_misalign}, 64'd1);
        out_q.push_back({32'h0000_0000, 32'h0000_3046});
        cyc(1);
        chk("mis_req_hold", {63'd0, imem_req}, 64'd0);
        stall = 1'b0;
        cyc(3);
`endif

        cyc(2);
        chk("addr_q_drained", {32'd0, 32'(addr_q.size())}, 64'd0);
        chk("out_q_drained", {32'd0, 32'(out_q.size())}, 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
